// File: rtl/lpddr5_controller_enum.sv
// DRAM command encoding shared by the LPDDR5 controller blocks.
// The ordinals are fixed; other blocks decode them directly.
package lpddr5_controller_enum;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } dram_cmd_t;

endpackage

// File: rtl/lpddr5_params.sv
// Default LPDDR5 timing values in controller clock cycles.
package lpddr5_params;

  localparam int tRCD  = 4;
  localparam int tRP   = 4;
  localparam int tRAS  = 10;
  localparam int tWR   = 6;
  localparam int tCCD  = 2;
  localparam int tRFC  = 20;
  localparam int tREFI = 3900;

endpackage

// File: rtl/lpddr5_timing_gate_pkg.sv
// Types local to the timing gate: the per-cycle decision taken on a request.
package lpddr5_timing_gate_pkg;

  // WAIT: nothing consumed (no request, or timing/backpressure hold)
  // ISSUE: consumed and driven onto the DRAM bus next cycle
  // DROP: consumed as protocol-illegal, error pulse next cycle
  // SKIP: consumed NOP request, no effect
  typedef enum logic [1:0] {
    DEC_WAIT  = 2'd0,
    DEC_ISSUE = 2'd1,
    DEC_DROP  = 2'd2,
    DEC_SKIP  = 2'd3
  } gate_dec_t;

endpackage

// File: rtl/lpddr5_bank_timer.sv
// Per-bank open/closed state, open row and the bank-local spacing counters.
// The *_ok outputs report timing only; state legality is decided by the top.
module lpddr5_bank_timer #(
  parameter int ROW_W = 16,
  parameter int TW    = 8,
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_RAS = 10,
  parameter int T_WR  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             act_go,
  input  logic             wr_go,
  input  logic             pre_go,
  input  logic [ROW_W-1:0] act_row,
  output logic             is_open,
  output logic [ROW_W-1:0] open_row,
  output logic             act_ok,
  output logic             rw_ok,
  output logic             pre_ok
);

  localparam logic [TW-1:0] RCD_LD = TW'(T_RCD - 1);
  localparam logic [TW-1:0] RP_LD  = TW'(T_RP - 1);
  localparam logic [TW-1:0] RAS_LD = TW'(T_RAS - 1);
  localparam logic [TW-1:0] WR_LD  = TW'(T_WR - 1);
  localparam logic [TW-1:0] ONE    = TW'(1);

  logic [TW-1:0] rcd_r, rp_r, ras_r, wr_r;

  // Bank open flag and captured row; ACT opens, PRE closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_open  <= 1'b0;
      open_row <= '0;
    end else if (act_go) begin
      is_open  <= 1'b1;
      open_row <= act_row;
    end else if (pre_go) begin
      is_open  <= 1'b0;
    end
  end

  // Spacing counters: a load on issue takes priority over the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcd_r <= '0;
      rp_r  <= '0;
      ras_r <= '0;
      wr_r  <= '0;
    end else begin
      if (act_go)              rcd_r <= RCD_LD;
      else if (rcd_r != '0)    rcd_r <= rcd_r - ONE;
      if (pre_go)              rp_r  <= RP_LD;
      else if (rp_r != '0)     rp_r  <= rp_r - ONE;
      if (act_go)              ras_r <= RAS_LD;
      else if (ras_r != '0)    ras_r <= ras_r - ONE;
      if (wr_go)               wr_r  <= WR_LD;
      else if (wr_r != '0)     wr_r  <= wr_r - ONE;
    end
  end

  assign act_ok = (rp_r == '0);
  assign rw_ok  = (rcd_r == '0);
  assign pre_ok = (ras_r == '0) && (wr_r == '0);

endmodule

// File: rtl/lpddr5_timing_gate.sv
// Timing and state gate between the scheduler and the DRAM command pins.
// Holds a request until its bank and global spacing constraints are met,
// drops state-illegal requests with an error pulse, and registers the bus.
module lpddr5_timing_gate
  import lpddr5_controller_enum::*;
  import lpddr5_timing_gate_pkg::*;
#(
  parameter int BANKS = 16,
  parameter int ROW_W = 16,
  parameter int COL_W = 10,
  parameter int TW    = 8,
  parameter int T_RCD = lpddr5_params::tRCD,
  parameter int T_RP  = lpddr5_params::tRP,
  parameter int T_RAS = lpddr5_params::tRAS,
  parameter int T_WR  = lpddr5_params::tWR,
  parameter int T_CCD = lpddr5_params::tCCD,
  parameter int T_RFC = lpddr5_params::tRFC,
  localparam int BW   = $clog2(BANKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  dram_cmd_t        req_cmd,
  input  logic [BW-1:0]    req_bank,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             req_ready,
  input  logic             phy_ready,
  output dram_cmd_t        dram_cmd,
  output logic [BW-1:0]    dram_bank,
  output logic [ROW_W-1:0] dram_row,
  output logic [COL_W-1:0] dram_col,
  output logic [BANKS-1:0] bank_open,
  output logic             err_illegal
);

  localparam logic [TW-1:0] CCD_LD = TW'(T_CCD - 1);
  localparam logic [TW-1:0] RFC_LD = TW'(T_RFC - 1);
  localparam logic [TW-1:0] ONE    = TW'(1);

  logic [BANKS-1:0] open_s, act_ok_s, rw_ok_s, pre_ok_s, hit_s;
  logic [ROW_W-1:0] row_tab_s [BANKS];
  logic [TW-1:0]    ccd_r, rfc_r;
  gate_dec_t        dec_s;
  logic             issue_s, go_s;
  logic             act_go_s, rd_go_s, wr_go_s, pre_go_s, ref_go_s;

  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    assign hit_s[i] = (req_bank == BW'(i));
    lpddr5_bank_timer #(
      .ROW_W(ROW_W), .TW(TW),
      .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_WR(T_WR)
    ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .act_go   (act_go_s && hit_s[i]),
      .wr_go    (wr_go_s && hit_s[i]),
      .pre_go   (pre_go_s && hit_s[i]),
      .act_row  (req_row),
      .is_open  (open_s[i]),
      .open_row (row_tab_s[i]),
      .act_ok   (act_ok_s[i]),
      .rw_ok    (rw_ok_s[i]),
      .pre_ok   (pre_ok_s[i])
    );
  end

  // Common issue condition: refresh window closed and PHY accepting.
  assign go_s = (rfc_r == '0) && phy_ready;

  // Legality mux: state violations are dropped regardless of timers/PHY,
  // state-legal requests wait for timing; unknown encodings are dropped.
  always_comb begin
    dec_s = DEC_WAIT;
    if (!req_valid) begin
      dec_s = DEC_WAIT;
    end else begin
      case (req_cmd)
        CMD_NOP: dec_s = DEC_SKIP;
        CMD_ACT: begin
          if (open_s[req_bank])                 dec_s = DEC_DROP;
          else if (go_s && act_ok_s[req_bank])  dec_s = DEC_ISSUE;
          else                                  dec_s = DEC_WAIT;
        end
        CMD_RD, CMD_WR: begin
          if (!open_s[req_bank])                                  dec_s = DEC_DROP;
          else if (go_s && rw_ok_s[req_bank] && (ccd_r == '0))    dec_s = DEC_ISSUE;
          else                                                    dec_s = DEC_WAIT;
        end
        CMD_PRE: begin
          if (!open_s[req_bank])                dec_s = DEC_DROP;
          else if (go_s && pre_ok_s[req_bank])  dec_s = DEC_ISSUE;
          else                                  dec_s = DEC_WAIT;
        end
        CMD_REF: begin
          if (|open_s)                          dec_s = DEC_DROP;
          else if (go_s && (&act_ok_s))         dec_s = DEC_ISSUE;
          else                                  dec_s = DEC_WAIT;
        end
        default: dec_s = DEC_DROP;
      endcase
    end
  end

  assign req_ready = (dec_s != DEC_WAIT);
  assign issue_s   = (dec_s == DEC_ISSUE);
  assign act_go_s  = issue_s && (req_cmd == CMD_ACT);
  assign rd_go_s   = issue_s && (req_cmd == CMD_RD);
  assign wr_go_s   = issue_s && (req_cmd == CMD_WR);
  assign pre_go_s  = issue_s && (req_cmd == CMD_PRE);
  assign ref_go_s  = issue_s && (req_cmd == CMD_REF);
  assign bank_open = open_s;

  // Global RD/WR spacing and refresh recovery counters; load beats decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccd_r <= '0;
      rfc_r <= '0;
    end else begin
      if (rd_go_s || wr_go_s)  ccd_r <= CCD_LD;
      else if (ccd_r != '0)    ccd_r <= ccd_r - ONE;
      if (ref_go_s)            rfc_r <= RFC_LD;
      else if (rfc_r != '0)    rfc_r <= rfc_r - ONE;
    end
  end

  // Registered DRAM bus: one-cycle command, address fields held between issues.
  // For RD/WR/PRE the row field carries the bank's open row being accessed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_cmd    <= CMD_NOP;
      dram_bank   <= '0;
      dram_row    <= '0;
      dram_col    <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= (dec_s == DEC_DROP);
      if (issue_s) begin
        dram_cmd  <= req_cmd;
        dram_bank <= req_bank;
        dram_col  <= req_col;
        dram_row  <= (req_cmd == CMD_ACT) ? req_row : row_tab_s[req_bank];
      end else begin
        dram_cmd  <= CMD_NOP;
      end
    end
  end

endmodule

// File: doc/lpddr5_timing_gate.md
# lpddr5_timing_gate

Per-bank timing and state gate between the LPDDR5 controller scheduler and the DRAM command pins. Accepts one DRAM command request per cycle (ACT, RD, WR, PRE, REF). It holds each request until every JEDEC-style spacing constraint for the target bank is met, then drives it on the registered DRAM command bus. It also tracks the open/closed state and open row of every bank, and flags protocol-illegal requests.

## Interface
- BANKS, 16, number of banks tracked
- ROW_W, 16, row address width
- COL_W, 10, column address width
- TW, 8, timing counter width; every timing parameter must be ≤ 2^TW−1
- T_RCD, 4, minimum cycles from ACT to RD/WR, same bank
- T_RP, 4, minimum cycles from PRE to ACT, same bank
- T_RAS, 10, minimum cycles from ACT to PRE, same bank
- T_WR, 6, minimum cycles from WR to PRE, same bank
- T_CCD, 2, minimum cycles between any two RD/WR commands
- T_RFC, 20, minimum cycles from REF to any next command
- All T_* parameters must be ≥ 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_cmd  in  dram_cmd_t  CMD_ACT/CMD_RD/CMD_WR/CMD_PRE/CMD_REF
- req_bank  in  $clog2(BANKS)  target bank (ignored for REF)
- req_row  in  ROW_W  row, used by ACT
- req_col  in  COL_W  column, used by RD/WR
- req_ready  out  1  request consumed this cycle
- phy_ready  in  1  downstream can take a command this cycle
- dram_cmd  out  dram_cmd_t  issued command, CMD_NOP when idle
- dram_bank  out  $clog2(BANKS)  bank of issued command
- dram_row  out  ROW_W  row of issued ACT
- dram_col  out  COL_W  column of issued RD/WR
- bank_open  out  BANKS  per-bank open flag
- err_illegal  out  1  one-cycle pulse: illegal request dropped

## Operation
- Bank state per bank: CLOSED → OPEN on ACT. OPEN → CLOSED on PRE. REF only from all-CLOSED. The open row is stored per bank.
- Counters: the per-bank counters are rcd, rp, ras, wr; the global counters are ccd and rfc. Issuing a command loads the relevant counter(s) with T_x−1. Each nonzero counter decrements by 1 every cycle. A constraint is met when its counter is 0.
- Counter loads per command:
  - ACT: loads rcd and ras.
  - RD: loads ccd.
  - WR: loads ccd and wr.
  - PRE: loads rp.
  - REF: loads rfc.
- Legality, in addition to rfc==0 and phy_ready for all commands:
  - ACT: bank CLOSED, rp==0.
  - RD/WR: bank OPEN, rcd==0, ccd==0.
  - PRE: bank OPEN, ras==0, wr==0.
  - REF: all banks CLOSED, all rp==0.
- Illegal by state (ACT to OPEN, RD/WR/PRE to CLOSED, REF with any bank OPEN):
  - Request is consumed: req_ready=1.
  - Nothing is issued; err_illegal pulses next cycle.
  - This happens regardless of timers and phy_ready.
- Waiting: a request that is legal by state but not yet by timing is held with req_ready=0. The requester must hold all req_* stable until it is accepted.
- CMD_NOP requests are consumed with no effect.

## Timing
- req_ready is combinational from the req_* fields, the counters, bank state and phy_ready.
- Issue latency: dram_* are registered. An accepted command at cycle t appears on dram_cmd in cycle t+1 for exactly one cycle; otherwise dram_cmd=CMD_NOP.
- Minimum spacing: a command issued at cycle t allows a dependent command to be accepted no earlier than cycle t+T_x.
- Simultaneous events: counter load and decrement in the same cycle → the load wins.
- Reset values: all counters 0, all banks CLOSED, dram_cmd=CMD_NOP, dram_bank/row/col=0, err_illegal=0, bank_open=0.
- Reset mid-operation: all state is discarded immediately; no command is issued after reset release until a new request arrives.

## Structure
- The shared package lpddr5_controller_enum holds dram_cmd_t. The ordinals CMD_NOP/ACT/RD/WR/PRE/REF are fixed there.
- Default T_* values come from lpddr5_params (tRCD, tRP, tRAS, tWR, tCCD, tRFC), next to tREFI.
- Sub-module lpddr5_bank_timer: one instance per bank via generate. It holds the open flag, the open row, and the rcd/rp/ras/wr counters, and outputs act_ok, rw_ok and pre_ok.
- The top level holds the ccd and rfc counters, the legality mux, and the output registers.

## Test plan
- Row open, read, close (defaults): ACT b3 r0x12 at t0, RD b3 issued at t0+1.
  - RD accepted at t0+4 and appears on dram_cmd at t0+5.
  - PRE accepted no earlier than t0+10.
- Write recovery: WR b1 accepted at t → PRE b1 held until t+6. bank_open[1]=0 after the PRE issues.
- Back-to-back reads to two open banks:
  - RD b0 at t, RD b2 at t+1 → second RD accepted at t+2 (T_CCD=2).
- Illegal requests:
  - RD to a CLOSED bank 5 → req_ready=1, dram_cmd stays NOP, err_illegal=1 for exactly one cycle.
  - ACT to an already OPEN bank → same response.
- Refresh:
  - REF with all banks closed and rp expired → issued. ACT b0 at t+1 stalls until t+20.
  - REF with bank 7 OPEN → err_illegal.
- Backpressure and reset:
  - phy_ready=0 for 5 cycles with a legal ACT pending → req_ready=0 and dram_cmd=NOP throughout; ACT issues the cycle after phy_ready rises.
  - rst_n asserted mid-tRFC → counters and bank_open clear; an ACT right after release is accepted immediately.
